histogram_accumulator: RTL and testbench

- Upstream controller for the `histogram` bin RAM. The RAM is single-port: `pixel` address, `write_i`, `data_i`, `data_o`, 1024 x 32 bits, read data valid one cycle after the address.
- Consumes a sensor pixel stream and does run-coalesced read-modify-write into the RAM.
- After end-of-frame it streams all bins out, clearing each bin as it is read, so the next frame starts from zero.
- Replaces the testbench-driven increment loop with synthesizable logic.

---
 rtl/histogram_pkg.sv | 31 +++
 rtl/hist_run_coalescer.sv | 59 +++++
 rtl/histogram_accumulator.sv | 251 +++++++++++++++++++++++++
 tb/tb_histogram_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram accumulator: sizes, state codes and
// the saturating adder used for both run counting and bin merging.
package histogram_pkg;

  // Pixel width doubles as the bin address width; one bin per pixel value.
  localparam int PIX_W = 10;
  localparam int BINS  = 1 << PIX_W;
  localparam int CNT_W = 32;

  // Controller state codes, kept as plain constants so older tools and
  // scripts that decode the raw state value keep working.
  typedef logic [2:0] state_t;

  localparam state_t ST_CLEAR    = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_ACCUM    = 3'd2;
  localparam state_t ST_FLUSH_RD = 3'd3;
  localparam state_t ST_FLUSH_WR = 3'd4;
  localparam state_t ST_RD_ADDR  = 3'd5;
  localparam state_t ST_RD_HOLD  = 3'd6;
  localparam state_t ST_RD_ZERO  = 3'd7;

  // Unsigned add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/hist_run_coalescer.sv
// Run coalescer: tracks the current run of identical pixels and hands a
// finished run over to the flush registers that feed the RAM update.
module hist_run_coalescer
  import histogram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             beat,
  input  logic             final_beat,
  input  logic             move,
  input  logic [PIX_W-1:0] pix,
  output logic             same,
  output logic [PIX_W-1:0] run_bin,
  output logic [CNT_W-1:0] run_cnt,
  output logic [PIX_W-1:0] flush_bin,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [CNT_W-1:0] inc_cnt;

  assign same    = (pix == run_bin);
  assign inc_cnt = sat_add(run_cnt, CNT_W'(1));

  // Run and flush registers. A start beat seeds both so that a one-beat frame
  // can be flushed straight away; a final beat on the same pixel hands the
  // grown run to flush in the same cycle; a differing pixel retires the old
  // run and starts a new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_bin   <= '0;
      run_cnt   <= '0;
      flush_bin <= '0;
      flush_cnt <= '0;
    end else if (start) begin
      run_bin   <= pix;
      run_cnt   <= CNT_W'(1);
      flush_bin <= pix;
      flush_cnt <= CNT_W'(1);
    end else if (beat) begin
      if (same) begin
        run_cnt <= inc_cnt;
        if (final_beat) begin
          flush_bin <= run_bin;
          flush_cnt <= inc_cnt;
        end
      end else begin
        flush_bin <= run_bin;
        flush_cnt <= run_cnt;
        run_bin   <= pix;
        run_cnt   <= CNT_W'(1);
      end
    end else if (move) begin
      flush_bin <= run_bin;
      flush_cnt <= run_cnt;
    end
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Histogram accumulator: clears the bin RAM, folds a pixel stream into it with
// run-coalesced read-modify-write, then streams every bin out and zeroes it.
module histogram_accumulator
  import histogram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             sof_i,
  input  logic             eof_i,
  output logic [PIX_W-1:0] hist_addr_o,
  output logic             hist_we_o,
  output logic [CNT_W-1:0] hist_wdata_o,
  input  logic [CNT_W-1:0] hist_rdata_i,
  output logic             hist_valid_o,
  input  logic             hist_ready_i,
  output logic [PIX_W-1:0] hist_bin_o,
  output logic [CNT_W-1:0] hist_count_o,
  output logic             hist_last_o,
  output logic             busy_o,
  output logic             err_o
);

  state_t           state;
  state_t           state_n;
  logic [PIX_W:0]   clr_idx;
  logic [PIX_W:0]   clr_idx_n;
  logic [PIX_W-1:0] bin;
  logic [PIX_W-1:0] bin_n;
  logic             final_flag;
  logic             final_n;
  logic             run_flushed;
  logic             run_flushed_n;
  logic             cap_valid;
  logic [CNT_W-1:0] cnt_q;
  logic [PIX_W-1:0] addr_n;
  logic             we_n;
  logic             err_n;
  logic             accept;

  logic             co_start;
  logic             co_beat;
  logic             co_final;
  logic             co_move;
  logic             same;
  logic [PIX_W-1:0] run_bin;
  logic [CNT_W-1:0] run_cnt;
  logic [PIX_W-1:0] flush_bin;
  logic [CNT_W-1:0] flush_cnt;

  assign accept = pix_valid_i && pix_ready_o;

  hist_run_coalescer u_coalescer (
    .clk        (clk),
    .reset      (reset),
    .start      (co_start),
    .beat       (co_beat),
    .final_beat (co_final),
    .move       (co_move),
    .pix        (pix_i),
    .same       (same),
    .run_bin    (run_bin),
    .run_cnt    (run_cnt),
    .flush_bin  (flush_bin),
    .flush_cnt  (flush_cnt)
  );

  // Next-state logic. RAM address and write enable are computed here for the
  // state being entered, so the registered outputs always match the state
  // they are shown in.
  always_comb begin
    state_n       = state;
    clr_idx_n     = clr_idx;
    bin_n         = bin;
    final_n       = final_flag;
    run_flushed_n = run_flushed;
    addr_n        = '0;
    we_n          = 1'b0;
    err_n         = 1'b0;
    co_start      = 1'b0;
    co_beat       = 1'b0;
    co_final      = 1'b0;
    co_move       = 1'b0;

    case (state)
      ST_CLEAR: begin
        if (!clr_idx[PIX_W]) begin
          we_n      = 1'b1;
          addr_n    = clr_idx[PIX_W-1:0];
          clr_idx_n = clr_idx + 1'b1;
        end else begin
          state_n   = ST_IDLE;
          clr_idx_n = '0;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (!sof_i) begin
            err_n = 1'b1;
          end else begin
            co_start = 1'b1;
            if (eof_i) begin
              final_n       = 1'b1;
              run_flushed_n = 1'b1;
              state_n       = ST_FLUSH_RD;
              addr_n        = pix_i;
            end else begin
              final_n       = 1'b0;
              run_flushed_n = 1'b0;
              state_n       = ST_ACCUM;
            end
          end
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          err_n    = sof_i;
          co_beat  = 1'b1;
          co_final = eof_i;
          if (same) begin
            if (eof_i) begin
              final_n       = 1'b1;
              run_flushed_n = 1'b1;
              state_n       = ST_FLUSH_RD;
              addr_n        = run_bin;
            end
          end else begin
            final_n       = eof_i;
            run_flushed_n = 1'b0;
            state_n       = ST_FLUSH_RD;
            addr_n        = run_bin;
          end
        end
      end

      ST_FLUSH_RD: begin
        state_n = ST_FLUSH_WR;
        addr_n  = flush_bin;
        we_n    = 1'b1;
      end

      ST_FLUSH_WR: begin
        if (final_flag && !run_flushed) begin
          co_move       = 1'b1;
          run_flushed_n = 1'b1;
          state_n       = ST_FLUSH_RD;
          addr_n        = run_bin;
        end else if (final_flag) begin
          final_n = 1'b0;
          bin_n   = '0;
          state_n = ST_RD_ADDR;
          addr_n  = '0;
        end else begin
          state_n = ST_ACCUM;
        end
      end

      ST_RD_ADDR: begin
        state_n = ST_RD_HOLD;
        addr_n  = bin;
      end

      ST_RD_HOLD: begin
        addr_n = bin;
        if (hist_ready_i) begin
          state_n = ST_RD_ZERO;
          we_n    = 1'b1;
        end
      end

      ST_RD_ZERO: begin
        if (bin == {PIX_W{1'b1}}) begin
          state_n = ST_IDLE;
        end else begin
          bin_n   = bin + 1'b1;
          state_n = ST_RD_ADDR;
          addr_n  = bin + 1'b1;
        end
      end

      default: begin
        state_n = ST_CLEAR;
      end
    endcase
  end

  // Control state, bookkeeping flags and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_CLEAR;
      clr_idx      <= '0;
      bin          <= '0;
      final_flag   <= 1'b0;
      run_flushed  <= 1'b0;
      hist_addr_o  <= '0;
      hist_we_o    <= 1'b0;
      pix_ready_o  <= 1'b0;
      hist_valid_o <= 1'b0;
      hist_bin_o   <= '0;
      hist_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_n;
      clr_idx      <= clr_idx_n;
      bin          <= bin_n;
      final_flag   <= final_n;
      run_flushed  <= run_flushed_n;
      hist_addr_o  <= addr_n;
      hist_we_o    <= we_n;
      pix_ready_o  <= (state_n == ST_IDLE) || (state_n == ST_ACCUM);
      hist_valid_o <= (state_n == ST_RD_HOLD);
      hist_bin_o   <= (state_n == ST_RD_HOLD) ? bin_n : '0;
      hist_last_o  <= (state_n == ST_RD_HOLD) && (bin_n == {PIX_W{1'b1}});
      busy_o       <= (state_n != ST_IDLE);
      err_o        <= err_n;
    end
  end

  // Readout count capture: the RAM word arriving in the first hold cycle is
  // latched so the count stays frozen however long the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cap_valid <= (state == ST_RD_HOLD) && (state_n == ST_RD_HOLD);
      if ((state == ST_RD_HOLD) && !cap_valid) begin
        cnt_q <= hist_rdata_i;
      end
    end
  end

  // Write data and readout count depend on the RAM word of the current cycle;
  // everywhere else they are held at zero.
  always_comb begin
    hist_wdata_o = '0;
    hist_count_o = '0;
    if (state == ST_FLUSH_WR) begin
      hist_wdata_o = sat_add(hist_rdata_i, flush_cnt);
    end
    if (state == ST_RD_HOLD) begin
      hist_count_o = cap_valid ? cnt_q : hist_rdata_i;
    end
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Testbench for histogram_accumulator with a behavioural bin RAM and a
// frame-level reference histogram.
module tb_histogram_accumulator;
  import histogram_pkg::*;

  localparam longint unsigned MAX_CNT = 64'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pix_valid_i = 1'b0;
  logic             pix_ready_o;
  logic [PIX_W-1:0] pix_i = '0;
  logic             sof_i = 1'b0;
  logic             eof_i = 1'b0;
  logic [PIX_W-1:0] hist_addr_o;
  logic             hist_we_o;
  logic [CNT_W-1:0] hist_wdata_o;
  logic [CNT_W-1:0] hist_rdata_i = '0;
  logic             hist_valid_o;
  logic             hist_ready_i = 1'b0;
  logic [PIX_W-1:0] hist_bin_o;
  logic [CNT_W-1:0] hist_count_o;
  logic             hist_last_o;
  logic             busy_o;
  logic             err_o;

  logic [CNT_W-1:0] ram [BINS];
  logic             fill_en = 1'b0;
  logic             poke_en = 1'b0;
  logic [PIX_W-1:0] poke_addr = '0;
  logic [CNT_W-1:0] poke_data = '0;

  longint unsigned  model [BINS];
  int               tests = 0;
  int               fails = 0;

  histogram_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .pix_i        (pix_i),
    .sof_i        (sof_i),
    .eof_i        (eof_i),
    .hist_addr_o  (hist_addr_o),
    .hist_we_o    (hist_we_o),
    .hist_wdata_o (hist_wdata_o),
    .hist_rdata_i (hist_rdata_i),
    .hist_valid_o (hist_valid_o),
    .hist_ready_i (hist_ready_i),
    .hist_bin_o   (hist_bin_o),
    .hist_count_o (hist_count_o),
    .hist_last_o  (hist_last_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Single-port bin RAM: synchronous write, read data one cycle after the
  // address. Fill and poke let the bench seed junk and preload values.
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < BINS; i++) ram[i] <= 32'hDEAD_0000 | 32'(i);
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (hist_we_o) begin
      ram[hist_addr_o] <= hist_wdata_o;
    end
    hist_rdata_i <= ram[hist_addr_o];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one pixel beat and wait for it to be taken; returns the number of
  // cycles the beat waited for pix_ready_o.
  task automatic applyStimulus(input int p, input logic s, input logic e, output int stall);
    pix_i = PIX_W'(p);
    sof_i = s;
    eof_i = e;
    pix_valid_i = 1'b1;
    stall = 0;
    while (!pix_ready_o && stall < 100) begin
      @(negedge clk);
      stall++;
    end
    if (!pix_ready_o) checkOutput("pix_ready_timeout", 64'(pix_ready_o), 64'd1);
    @(negedge clk);
    pix_valid_i = 1'b0;
    sof_i = 1'b0;
    eof_i = 1'b0;
  endtask

  // Send a frame and fold it into the reference histogram. Only a pixel that
  // changed the run stalls the next beat, by two cycles.
  task automatic sendFrame(input int q[$]);
    int st;
    int exp_st;
    for (int i = 0; i < q.size(); i++) begin
      applyStimulus(q[i], i == 0, i == q.size() - 1, st);
      exp_st = (i >= 2 && q[i-1] != q[i-2]) ? 2 : 0;
      checkOutput("input_stall", 64'(st), 64'(exp_st));
      if (model[q[i]] < MAX_CNT) model[q[i]] = model[q[i]] + 1;
    end
  endtask

  // Drain every bin against the reference. hold_bin is stalled for
  // hold_cycles with stability checks; abort asserts reset there instead.
  task automatic readFrame(input int hold_bin, input int hold_cycles, input bit abort, input bit rand_bp);
    int g;
    int n;
    logic [63:0] expv;
    for (int b = 0; b < BINS; b++) begin
      g = 0;
      while (!hist_valid_o && g < 30) begin
        @(negedge clk);
        g++;
      end
      expv = 64'({1'b1, b[PIX_W-1:0], model[b][CNT_W-1:0], (b == BINS - 1)});
      checkOutput("readout_bin", 64'({hist_valid_o, hist_bin_o, hist_count_o, hist_last_o}), expv);
      n = (b == hold_bin) ? hold_cycles : ((rand_bp && $urandom_range(0, 3) == 0) ? 1 : 0);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (b == hold_bin)
          checkOutput("hold_stable", 64'({hist_valid_o, hist_bin_o, hist_count_o, hist_last_o}), expv);
      end
      if (abort && b == hold_bin) begin
        reset = 1'b1;
        #1;
        checkOutput("reset_outputs", 64'({hist_valid_o, hist_bin_o, hist_count_o, hist_last_o,
                    pix_ready_o, hist_we_o, busy_o, err_o, hist_wdata_o}), 64'd0);
        for (int i = 0; i < BINS; i++) model[i] = 0;
        return;
      end
      hist_ready_i = 1'b1;
      @(negedge clk);
      hist_ready_i = 1'b0;
    end
    for (int i = 0; i < BINS; i++) model[i] = 0;
    g = 0;
    while (busy_o && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("idle_after_readout", 64'({busy_o, pix_ready_o}), 64'b01);
  endtask

  // After reset release: every bin written with zero in address order, then
  // the controller becomes ready for pixels.
  task automatic checkClear();
    int n = 0;
    int bad = 0;
    int g = 0;
    while (!pix_ready_o && g < BINS + 20) begin
      if (hist_we_o) begin
        if (hist_addr_o !== PIX_W'(n) || hist_wdata_o !== '0) bad++;
        n++;
      end
      @(negedge clk);
      g++;
    end
    checkOutput("clear_writes", 64'(n), 64'(BINS));
    checkOutput("clear_addr_data", 64'(bad), 64'd0);
    checkOutput("idle_ready", 64'({pix_ready_o, busy_o, hist_we_o}), 64'b100);
  endtask

  initial begin
    int frame[$];
    int st;
    int v;
    int len;

    for (int i = 0; i < BINS; i++) model[i] = 0;

    // Reset with junk in the RAM; outputs must all be zero.
    fill_en = 1'b1;
    repeat (3) @(negedge clk);
    fill_en = 1'b0;
    checkOutput("reset_outputs", 64'({hist_valid_o, hist_bin_o, hist_count_o, hist_last_o,
                pix_ready_o, hist_we_o, busy_o, err_o, hist_addr_o}), 64'd0);
    reset = 1'b0;
    checkClear();

    // Short frame with two runs, then the same frame again.
    frame = '{5, 5, 5, 7, 7};
    sendFrame(frame);
    readFrame(-1, 0, 1'b0, 1'b0);
    sendFrame(frame);
    readFrame(-1, 0, 1'b0, 1'b0);

    // Alternating pixels: every beat changes the run.
    frame.delete();
    for (int i = 0; i < 100; i++) begin
      frame.push_back(1);
      frame.push_back(2);
    end
    sendFrame(frame);
    readFrame(-1, 0, 1'b0, 1'b0);

    // Stray beat without sof in IDLE, then a single-beat frame.
    applyStimulus(1023, 1'b0, 1'b0, st);
    checkOutput("err_pulse", 64'(err_o), 64'd1);
    @(negedge clk);
    checkOutput("err_clear", 64'({err_o, pix_ready_o}), 64'b01);
    frame = '{1023};
    sendFrame(frame);
    readFrame(-1, 0, 1'b0, 1'b0);

    // Near-full bin pushed past the top by a run of 32 pixels.
    poke_addr = PIX_W'(9);
    poke_data = 32'hFFFF_FFF0;
    poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    model[9] = 64'hFFFF_FFF0;
    frame.delete();
    for (int i = 0; i < 32; i++) frame.push_back(9);
    sendFrame(frame);
    checkOutput("saturated_model", model[9], MAX_CNT);
    readFrame(-1, 0, 1'b0, 1'b0);

    // Random runs with random readout backpressure.
    for (int f = 0; f < 2; f++) begin
      frame.delete();
      for (int r = 0; r < int'($urandom_range(3, 8)); r++) begin
        v = int'($urandom_range(0, BINS - 1));
        len = int'($urandom_range(1, 6));
        for (int k = 0; k < len; k++) frame.push_back(v);
      end
      sendFrame(frame);
      readFrame(-1, 0, 1'b0, 1'b1);
    end

    // Long stall on bin 3, then reset in the middle of the readout.
    frame = '{3, 3, 3, 4};
    sendFrame(frame);
    readFrame(3, 50, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    checkClear();

    // The interrupted frame must be gone.
    frame = '{5, 5, 5, 7, 7};
    sendFrame(frame);
    readFrame(-1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
